// File: rtl/ex_stage_mdu.sv
`timescale 1ns/1ps
// MIPS execute stage: operand forwarding, ALU, EX/MEM register and an iterative unsigned MULTU/DIVU unit owning HI/LO.
// Define EX_DIV_EN to build the restoring divider; without it DIVU behaves as an ordinary ALU instruction.
module ex_stage_mdu #(
   parameter int LEN                  = 32,
   parameter int NB_ADDRESS_REGISTROS = 5,
   parameter int NB_ALU_CONTROL       = 4,
   parameter int NB_CTRL_WB           = 2,
   parameter int NB_CTRL_MEM          = 3,
   parameter int NB_CTRL_EX           = 6
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_valid,
   input  logic [LEN-1:0]                  i_adder_id,
   input  logic [LEN-1:0]                  i_dato1,
   input  logic [LEN-1:0]                  i_dato2,
   input  logic [LEN-1:0]                  i_sign_extend,
   input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
   input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
   input  logic [NB_CTRL_EX-1:0]           i_ctrl_ex,
   input  logic [2:0]                      i_mdu_op,
   input  logic [NB_ADDRESS_REGISTROS-1:0] i_rs,
   input  logic [NB_ADDRESS_REGISTROS-1:0] i_rt,
   input  logic [NB_ADDRESS_REGISTROS-1:0] i_rd,
   input  logic                            i_fwd_mem_we,
   input  logic                            i_fwd_wb_we,
   input  logic [NB_ADDRESS_REGISTROS-1:0] i_fwd_mem_reg,
   input  logic [NB_ADDRESS_REGISTROS-1:0] i_fwd_wb_reg,
   input  logic [LEN-1:0]                  i_fwd_mem_data,
   input  logic [LEN-1:0]                  i_fwd_wb_data,
   output logic                            o_stall,
   output logic                            o_alu_zero,
   output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
   output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
   output logic [NB_CTRL_MEM-1:0]          o_ctrl_mem,
   output logic [LEN-1:0]                  o_add_execute,
   output logic [LEN-1:0]                  o_alu_result,
   output logic [LEN-1:0]                  o_dato2
);

   localparam int NB_CNT = $clog2(LEN);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_MFHI  = 3'd3;
   localparam logic [2:0] OP_MFLO  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef EX_DIV_EN
   localparam logic [2:0] OP_DIVU  = 3'd2;
`endif

   localparam logic [NB_ALU_CONTROL-1:0] ALU_AND = NB_ALU_CONTROL'(0);
   localparam logic [NB_ALU_CONTROL-1:0] ALU_OR  = NB_ALU_CONTROL'(1);
   localparam logic [NB_ALU_CONTROL-1:0] ALU_ADD = NB_ALU_CONTROL'(2);
   localparam logic [NB_ALU_CONTROL-1:0] ALU_XOR = NB_ALU_CONTROL'(3);
   localparam logic [NB_ALU_CONTROL-1:0] ALU_NOR = NB_ALU_CONTROL'(4);
   localparam logic [NB_ALU_CONTROL-1:0] ALU_SUB = NB_ALU_CONTROL'(6);
   localparam logic [NB_ALU_CONTROL-1:0] ALU_SLT = NB_ALU_CONTROL'(7);

   logic [NB_ALU_CONTROL-1:0] alu_op;
   logic                      alu_src;
   logic                      reg_dst;
   assign alu_op  = i_ctrl_ex[NB_ALU_CONTROL-1:0];
   assign alu_src = i_ctrl_ex[NB_ALU_CONTROL];
   assign reg_dst = i_ctrl_ex[NB_ALU_CONTROL+1];

   // Index 0 is operand A (rs), index 1 is operand B (rt); MEM beats WB, $zero is never bypassed.
   logic [NB_ADDRESS_REGISTROS-1:0] src_reg [2];
   logic [LEN-1:0]                  rf_val  [2];
   logic [LEN-1:0]                  fwd_val [2];
   assign src_reg[0] = i_rs;
   assign src_reg[1] = i_rt;
   assign rf_val[0]  = i_dato1;
   assign rf_val[1]  = i_dato2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         logic hit_mem;
         logic hit_wb;
         assign hit_mem = i_fwd_mem_we && (i_fwd_mem_reg == src_reg[gi]) && (src_reg[gi] != '0);
         assign hit_wb  = i_fwd_wb_we  && (i_fwd_wb_reg  == src_reg[gi]) && (src_reg[gi] != '0);
         assign fwd_val[gi] = hit_mem ? i_fwd_mem_data : (hit_wb ? i_fwd_wb_data : rf_val[gi]);
      end
   endgenerate

   logic [LEN-1:0] op_a, op_b, alu_b, alu_out, result_next;
   assign op_a  = fwd_val[0];
   assign op_b  = fwd_val[1];
   assign alu_b = alu_src ? i_sign_extend : op_b;

   always_comb begin
      alu_out = '0;
      case (alu_op)
         ALU_AND: alu_out = op_a & alu_b;
         ALU_OR:  alu_out = op_a | alu_b;
         ALU_ADD: alu_out = op_a + alu_b;
         ALU_XOR: alu_out = op_a ^ alu_b;
         ALU_NOR: alu_out = ~(op_a | alu_b);
         ALU_SUB: alu_out = op_a - alu_b;
         ALU_SLT: alu_out = LEN'($signed(op_a) < $signed(alu_b));
         default: alu_out = '0;
      endcase
   end

   logic [1:0]        state_reg;
   logic [NB_CNT-1:0] cnt_reg;
   logic [LEN-1:0]    acc_reg, mq_reg, m_reg, hi_reg, lo_reg;
   logic              is_div_op, start, mdu_stall;

`ifdef EX_DIV_EN
   assign is_div_op = (i_mdu_op == OP_DIVU);
`else
   assign is_div_op = 1'b0;
`endif
   assign start     = i_valid && ((i_mdu_op == OP_MULTU) || is_div_op);
   assign mdu_stall = ((state_reg == ST_IDLE) && start) || (state_reg == ST_BUSY);
   assign o_stall   = mdu_stall && !i_rst;

   // mq holds the multiplier (shifted out LSB first) or the dividend (shifted out MSB first).
   logic [LEN:0]   mul_sum;
   logic [LEN-1:0] acc_next, mq_next;
   assign mul_sum = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, m_reg} : {(LEN+1){1'b0}});

`ifdef EX_DIV_EN
   logic           is_div_reg;
   logic [LEN:0]   div_shift;
   logic [LEN+1:0] div_diff;
   logic           div_ge, div_unused;
   assign div_shift  = {acc_reg, mq_reg[LEN-1]};
   assign div_diff   = {1'b0, div_shift} - {2'b00, m_reg};
   assign div_ge     = !div_diff[LEN+1];
   assign div_unused = div_diff[LEN];
   assign acc_next   = is_div_reg ? (div_ge ? div_diff[LEN-1:0] : div_shift[LEN-1:0]) : mul_sum[LEN:1];
   assign mq_next    = is_div_reg ? {mq_reg[LEN-2:0], div_ge} : {mul_sum[0], mq_reg[LEN-1:1]};
`else
   assign acc_next   = mul_sum[LEN:1];
   assign mq_next    = {mul_sum[0], mq_reg[LEN-1:1]};
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         acc_reg   <= '0;
         mq_reg    <= '0;
         m_reg     <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
`ifdef EX_DIV_EN
         is_div_reg <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  mq_reg    <= op_a;
                  m_reg     <= op_b;
                  acc_reg   <= '0;
                  cnt_reg   <= NB_CNT'(LEN-1);
                  state_reg <= ST_BUSY;
`ifdef EX_DIV_EN
                  is_div_reg <= is_div_op;
`endif
               end
            end
            ST_BUSY: begin
               acc_reg <= acc_next;
               mq_reg  <= mq_next;
               if (cnt_reg == '0) begin
                  hi_reg    <= acc_next;
                  lo_reg    <= mq_next;
                  state_reg <= ST_DONE;
               end else begin
                  cnt_reg <= cnt_reg - NB_CNT'(1);
               end
            end
            ST_DONE: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
         // MTHI/MTLO commit on the edge that retires them, never while the unit is stalling.
         if (i_valid && !mdu_stall) begin
            if (i_mdu_op == OP_MTHI)
               hi_reg <= op_a;
            else if (i_mdu_op == OP_MTLO)
               lo_reg <= op_a;
         end
      end
   end

   always_comb begin
      result_next = alu_out;
      if (i_mdu_op == OP_MFHI)
         result_next = hi_reg;
      else if (i_mdu_op == OP_MFLO)
         result_next = lo_reg;
   end

   logic                            alu_zero_reg;
   logic [NB_ADDRESS_REGISTROS-1:0] write_reg_reg;
   logic [NB_CTRL_WB-1:0]           ctrl_wb_reg;
   logic [NB_CTRL_MEM-1:0]          ctrl_mem_reg;
   logic [LEN-1:0]                  add_execute_reg, alu_result_reg, dato2_reg;

   // A bubble clears only the control side; data fields keep their last value.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         alu_zero_reg    <= 1'b0;
         write_reg_reg   <= '0;
         ctrl_wb_reg     <= '0;
         ctrl_mem_reg    <= '0;
         add_execute_reg <= '0;
         alu_result_reg  <= '0;
         dato2_reg       <= '0;
      end else if (mdu_stall || !i_valid) begin
         alu_zero_reg    <= 1'b0;
         write_reg_reg   <= '0;
         ctrl_wb_reg     <= '0;
         ctrl_mem_reg    <= '0;
      end else begin
         alu_zero_reg    <= (alu_out == '0);
         write_reg_reg   <= reg_dst ? i_rd : i_rt;
         ctrl_wb_reg     <= i_ctrl_wb;
         ctrl_mem_reg    <= i_ctrl_mem;
         add_execute_reg <= i_adder_id + (i_sign_extend << 2);
         alu_result_reg  <= result_next;
         dato2_reg       <= op_b;
      end
   end

   assign o_alu_zero    = alu_zero_reg;
   assign o_write_reg   = write_reg_reg;
   assign o_ctrl_wb     = ctrl_wb_reg;
   assign o_ctrl_mem    = ctrl_mem_reg;
   assign o_add_execute = add_execute_reg;
   assign o_alu_result  = alu_result_reg;
   assign o_dato2       = dato2_reg;

endmodule

// File: tb/tb_ex_stage_mdu.sv
`timescale 1ns/1ps
// Scoreboard bench for ex_stage_mdu: expected EX/MEM contents are queued at issue and compared at retirement.
module tb_ex_stage_mdu;

   localparam int LEN = 32;

   localparam logic [3:0] ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_ADD = 4'd2, ALU_XOR = 4'd3;
   localparam logic [3:0] ALU_NOR = 4'd4, ALU_SUB = 4'd6, ALU_SLT = 4'd7;
   localparam logic [2:0] MDU_NONE = 3'd0, MULTU = 3'd1, DIVU = 3'd2, MFHI = 3'd3;
   localparam logic [2:0] MFLO = 3'd4, MTHI = 3'd5, MTLO = 3'd6;
   localparam logic [3:0] TBL_OP [8] = '{ALU_ADD, ALU_SUB, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT};

   logic        clk, rst, valid;
   logic [31:0] adder_id, dato1, dato2, sext;
   logic [1:0]  ctrl_wb;
   logic [2:0]  ctrl_mem;
   logic [3:0]  alu_op;
   logic        alu_src, reg_dst;
   logic [5:0]  ctrl_ex;
   logic [2:0]  mdu_op;
   logic [4:0]  rs, rt, rd;
   logic        fwd_mem_we, fwd_wb_we;
   logic [4:0]  fwd_mem_reg, fwd_wb_reg;
   logic [31:0] fwd_mem_data, fwd_wb_data;
   logic        o_stall, o_alu_zero;
   logic [4:0]  o_write_reg;
   logic [1:0]  o_ctrl_wb;
   logic [2:0]  o_ctrl_mem;
   logic [31:0] o_add_execute, o_alu_result, o_dato2;

   assign ctrl_ex = {reg_dst, alu_src, alu_op};

   ex_stage_mdu dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_adder_id(adder_id),
      .i_dato1(dato1), .i_dato2(dato2), .i_sign_extend(sext),
      .i_ctrl_wb(ctrl_wb), .i_ctrl_mem(ctrl_mem), .i_ctrl_ex(ctrl_ex), .i_mdu_op(mdu_op),
      .i_rs(rs), .i_rt(rt), .i_rd(rd),
      .i_fwd_mem_we(fwd_mem_we), .i_fwd_wb_we(fwd_wb_we),
      .i_fwd_mem_reg(fwd_mem_reg), .i_fwd_wb_reg(fwd_wb_reg),
      .i_fwd_mem_data(fwd_mem_data), .i_fwd_wb_data(fwd_wb_data),
      .o_stall(o_stall), .o_alu_zero(o_alu_zero), .o_write_reg(o_write_reg),
      .o_ctrl_wb(o_ctrl_wb), .o_ctrl_mem(o_ctrl_mem), .o_add_execute(o_add_execute),
      .o_alu_result(o_alu_result), .o_dato2(o_dato2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic [1:0]  wb;
      logic [2:0]  mem;
      logic [4:0]  wr;
      logic [31:0] add;
      logic [31:0] d2;
   } exp_t;

   exp_t        sb_q [$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] hi_m, lo_m, last_res, last_add, last_d2;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_XOR: return a ^ b;
         ALU_NOR: return ~(a | b);
         ALU_SUB: return a - b;
         ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] fwd_model(input logic [4:0] r, input logic [31:0] rf);
      if (r != 5'd0 && fwd_mem_we && fwd_mem_reg == r) return fwd_mem_data;
      if (r != 5'd0 && fwd_wb_we && fwd_wb_reg == r) return fwd_wb_data;
      return rf;
   endfunction

   task automatic set_instr(input logic [2:0] mop, input logic [3:0] aop, input logic src, input logic dst,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                            input logic [31:0] pc, input logic [4:0] rs_v, input logic [4:0] rt_v,
                            input logic [4:0] rd_v, input logic [1:0] wb, input logic [2:0] mem);
      valid = 1'b1; mdu_op = mop; alu_op = aop; alu_src = src; reg_dst = dst;
      dato1 = a; dato2 = b; sext = imm; adder_id = pc;
      rs = rs_v; rt = rt_v; rd = rd_v; ctrl_wb = wb; ctrl_mem = mem;
      fwd_mem_we = 1'b0; fwd_wb_we = 1'b0; fwd_mem_reg = 5'd0; fwd_wb_reg = 5'd0;
      fwd_mem_data = 32'h0; fwd_wb_data = 32'h0;
   endtask

   task automatic push_exp();
      exp_t        e;
      logic [31:0] a, b, alu;
      a   = fwd_model(rs, dato1);
      b   = fwd_model(rt, dato2);
      alu = alu_model(alu_op, a, alu_src ? sext : b);
      if (valid) begin
         e.res  = (mdu_op == MFHI) ? hi_m : ((mdu_op == MFLO) ? lo_m : alu);
         e.zero = (alu == 32'h0);
         e.wb   = ctrl_wb;
         e.mem  = ctrl_mem;
         e.wr   = reg_dst ? rd : rt;
         e.add  = adder_id + (sext << 2);
         e.d2   = b;
         last_res = e.res; last_add = e.add; last_d2 = e.d2;
      end else begin
         e.res = last_res; e.zero = 1'b0; e.wb = 2'd0; e.mem = 3'd0; e.wr = 5'd0;
         e.add = last_add; e.d2 = last_d2;
      end
      sb_q.push_back(e);
   endtask

   task automatic retire_check(input string tag);
      exp_t e;
      @(posedge clk); #1;
      check_eq({tag, ".sb_depth"}, sb_q.size(), 1);
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      check_eq({tag, ".res"},  o_alu_result, e.res);
      check_eq({tag, ".zero"}, o_alu_zero, e.zero);
      check_eq({tag, ".wb"},   o_ctrl_wb, e.wb);
      check_eq({tag, ".mem"},  o_ctrl_mem, e.mem);
      check_eq({tag, ".wr"},   o_write_reg, e.wr);
      check_eq({tag, ".add"},  o_add_execute, e.add);
      check_eq({tag, ".d2"},   o_dato2, e.d2);
      $display("txn %-16s res=%h wb=%0h mem=%0h wr=%0d add=%h d2=%h", tag, o_alu_result, o_ctrl_wb,
               o_ctrl_mem, o_write_reg, o_add_execute, o_dato2);
   endtask

   task automatic single(input string tag);
      push_exp();
      #1;
      check_eq({tag, ".stall"}, o_stall, 0);
      retire_check(tag);
   endtask

   task automatic mf(input string tag, input logic [2:0] op);
      set_instr(op, ALU_ADD, 1'b0, 1'b1, 32'h11, 32'h22, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 2'b10, 3'b000);
      single(tag);
   endtask

   task automatic run_mdu(input string tag, input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b);
      logic        active;
      logic [63:0] full;
      int          stall_cnt;
      active = (mop == MULTU);
`ifdef EX_DIV_EN
      if (mop == DIVU) active = 1'b1;
`endif
      if (mop == MULTU) full = {32'h0, a} * {32'h0, b};
      else if (b == 32'h0) full = {a, 32'hFFFF_FFFF};
      else full = {a % b, a / b};
      set_instr(mop, ALU_ADD, 1'b0, 1'b1, a, b, 32'h4, 32'h200, 5'd4, 5'd5, 5'd6, 2'b10, 3'b001);
      push_exp();
      stall_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!o_stall) break;
         stall_cnt++;
         @(posedge clk);
      end
      check_eq({tag, ".stall_cycles"}, stall_cnt, active ? LEN + 1 : 0);
      if (active) check_eq({tag, ".bubble_wb"}, o_ctrl_wb, 0);
      retire_check(tag);
      if (active) begin
         hi_m = full[63:32];
         lo_m = full[31:0];
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      hi_m = 0; lo_m = 0; last_res = 0; last_add = 0; last_d2 = 0;
      rst = 1'b1;
      set_instr(MDU_NONE, ALU_ADD, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000);
      valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset.res", o_alu_result, 0);
      check_eq("reset.wb", o_ctrl_wb, 0);
      check_eq("reset.stall", o_stall, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // ALU sweep
      for (int i = 0; i < 8; i++) begin
         logic [31:0] a, b;
         a = $urandom; b = $urandom;
         if (i == 2) b = a;
         if (TBL_OP[i] == ALU_SLT) begin a = 32'hFFFF_FFFB; b = 32'd3; end
         set_instr(MDU_NONE, TBL_OP[i], 1'b0, i[0], a, b, 32'h8, 32'h40, 5'd2, 5'd3, 5'd7, 2'b11, 3'b010);
         single($sformatf("alu%0d", i));
         if (i == 2) check_eq("sub_zero", o_alu_zero, 1);
         if (i == 7) check_eq("slt_signed", o_alu_result, 1);
      end

      // Forwarding priority
      set_instr(MDU_NONE, ALU_ADD, 1'b1, 1'b1, 32'h30, 32'h5, 32'h1, 32'h0, 5'd8, 5'd9, 5'd10, 2'b01, 3'b000);
      fwd_mem_we = 1'b1; fwd_mem_reg = 5'd8; fwd_mem_data = 32'h10;
      fwd_wb_we = 1'b1; fwd_wb_reg = 5'd8; fwd_wb_data = 32'h20;
      single("fwd_mem");
      check_eq("fwd_mem_prio", o_alu_result, 32'h11);
      set_instr(MDU_NONE, ALU_ADD, 1'b1, 1'b1, 32'h30, 32'h5, 32'h1, 32'h0, 5'd0, 5'd9, 5'd10, 2'b01, 3'b000);
      fwd_mem_we = 1'b1; fwd_mem_reg = 5'd0; fwd_mem_data = 32'h10;
      fwd_wb_we = 1'b1; fwd_wb_reg = 5'd0; fwd_wb_data = 32'h20;
      single("fwd_r0");
      check_eq("fwd_r0_none", o_alu_result, 32'h31);
      set_instr(MDU_NONE, ALU_ADD, 1'b1, 1'b1, 32'h30, 32'h5, 32'h1, 32'h0, 5'd8, 5'd9, 5'd10, 2'b01, 3'b000);
      fwd_wb_we = 1'b1; fwd_wb_reg = 5'd8; fwd_wb_data = 32'h20;
      single("fwd_wb");
      check_eq("fwd_wb_only", o_alu_result, 32'h21);
      set_instr(MDU_NONE, ALU_ADD, 1'b0, 1'b1, 32'h1, 32'h66, 32'h0, 32'h0, 5'd0, 5'd9, 5'd10, 2'b01, 3'b100);
      fwd_mem_we = 1'b1; fwd_mem_reg = 5'd9; fwd_mem_data = 32'h7;
      fwd_wb_we = 1'b1; fwd_wb_reg = 5'd9; fwd_wb_data = 32'h9;
      single("fwd_b");
      check_eq("fwd_b_store", o_dato2, 32'h7);

      // Bubble and branch target
      set_instr(MDU_NONE, ALU_ADD, 1'b0, 1'b1, 32'h9, 32'h9, 32'h1, 32'h0, 5'd1, 5'd2, 5'd3, 2'b11, 3'b111);
      valid = 1'b0;
      single("bubble");
      check_eq("bubble_ctrl", {o_ctrl_wb, o_ctrl_mem}, 0);
      set_instr(MDU_NONE, ALU_ADD, 1'b1, 1'b0, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'h100, 5'd1, 5'd2, 5'd3, 2'b01, 3'b000);
      single("branch");
      check_eq("branch_target", o_add_execute, 32'hFC);

      // MULTU, then MF* immediately after
      run_mdu("multu_ffff", MULTU, 32'hFFFF_FFFF, 32'd2);
      mf("mflo_a", MFLO);
      check_eq("mflo_value", o_alu_result, 32'hFFFF_FFFE);
      mf("mfhi_a", MFHI);
      check_eq("mfhi_value", o_alu_result, 32'h1);
      run_mdu("multu_b2b_1", MULTU, 32'd7, 32'd6);
      run_mdu("multu_b2b_2", MULTU, 32'h0001_0000, 32'h0001_0000);
      mf("mfhi_b", MFHI);
      mf("mflo_b", MFLO);

      // DIVU
`ifdef EX_DIV_EN
      run_mdu("divu_100_7", DIVU, 32'd100, 32'd7);
      mf("mflo_div", MFLO);
      check_eq("div_quot", o_alu_result, 32'd14);
      mf("mfhi_div", MFHI);
      check_eq("div_rem", o_alu_result, 32'd2);
      run_mdu("divu_5_0", DIVU, 32'd5, 32'd0);
      mf("mflo_div0", MFLO);
      check_eq("div0_quot", o_alu_result, 32'hFFFF_FFFF);
      mf("mfhi_div0", MFHI);
      check_eq("div0_rem", o_alu_result, 32'd5);
`else
      run_mdu("divu_off", DIVU, 32'd100, 32'd7);
      mf("mfhi_divoff", MFHI);
      check_eq("divoff_hi", o_alu_result, 32'h1);
      mf("mflo_divoff", MFLO);
      check_eq("divoff_lo", o_alu_result, 32'h0);
`endif

      // MTHI / MTLO
      set_instr(MTHI, ALU_ADD, 1'b0, 1'b1, 32'hABCD, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 2'b00, 3'b000);
      single("mthi");
      hi_m = 32'hABCD;
      mf("mfhi_mt", MFHI);
      check_eq("mthi_value", o_alu_result, 32'hABCD);
      set_instr(MTLO, ALU_ADD, 1'b0, 1'b1, 32'h1357, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 2'b00, 3'b000);
      single("mtlo");
      lo_m = 32'h1357;
      mf("mflo_mt", MFLO);

      // Reset in BUSY cycle 10 of a MULTU
      set_instr(MULTU, ALU_ADD, 1'b0, 1'b1, 32'h1234, 32'h5678, 32'h0, 32'h0, 5'd4, 5'd5, 5'd6, 2'b11, 3'b111);
      @(negedge clk);
      check_eq("rst.issue_stall", o_stall, 1);
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
      end
      check_eq("rst.busy_stall", o_stall, 1);
      rst = 1'b1;
      #1;
      check_eq("rst.stall", o_stall, 0);
      check_eq("rst.res", o_alu_result, 0);
      check_eq("rst.add", o_add_execute, 0);
      check_eq("rst.d2", o_dato2, 0);
      check_eq("rst.ctrl", {o_ctrl_wb, o_ctrl_mem, o_write_reg, o_alu_zero}, 0);
      valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      hi_m = 0; lo_m = 0; last_res = 0; last_add = 0; last_d2 = 0;
      mf("mfhi_rst", MFHI);
      check_eq("rst.hi", o_alu_result, 0);
      mf("mflo_rst", MFLO);
      check_eq("rst.lo", o_alu_result, 0);
      run_mdu("multu_3x4", MULTU, 32'd3, 32'd4);
      mf("mflo_12", MFLO);
      check_eq("multu_3x4_lo", o_alu_result, 32'd12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ex_stage_mdu.md
# ex_stage_mdu

Parametrised MIPS execute stage with operand forwarding and an iterative unsigned multiply/divide unit holding HI/LO. It sits between the ID/EX and EX/MEM pipeline boundaries and owns the EX/MEM register. While a MULTU/DIVU is in flight it asserts `o_stall` so upstream stages freeze.

## Interface
- `LEN`, 32, datapath width; must be ≥ 4.
- `NB_ADDRESS_REGISTROS`, 5, register address width.
- `NB_ALU_CONTROL`, 4, ALU opcode width.
- `NB_CTRL_WB`, 2, WB control width.
- `NB_CTRL_MEM`, 3, MEM control width.
- `NB_CTRL_EX`, 6, EX control: [5] RegDst, [4] ALUSrc, [3:0] ALU opcode.

Ports:
- `i_clk`, in, 1, single clock; all state changes on the rising edge.
- `i_rst`, in, 1, asynchronous active-high reset.
- `i_valid`, in, 1, ID/EX holds a real instruction.
- `i_adder_id`, in, LEN, PC+4.
- `i_dato1`, `i_dato2`, in, LEN, register-file rs and rt values.
- `i_sign_extend`, in, LEN, immediate.
- `i_ctrl_wb`, in, NB_CTRL_WB, WB control.
- `i_ctrl_mem`, in, NB_CTRL_MEM, MEM control.
- `i_ctrl_ex`, in, NB_CTRL_EX, EX control as above.
- `i_mdu_op`, in, 3, MDU operation: 0 none, 1 MULTU, 2 DIVU, 3 MFHI, 4 MFLO, 5 MTHI, 6 MTLO.
- `i_rs`, `i_rt`, `i_rd`, in, NB_ADDRESS_REGISTROS, register addresses.
- `i_fwd_mem_we`, `i_fwd_wb_we`, in, 1, MEM/WB stages will write a register.
- `i_fwd_mem_reg`, `i_fwd_wb_reg`, in, NB_ADDRESS_REGISTROS, destination registers of those stages.
- `i_fwd_mem_data`, `i_fwd_wb_data`, in, LEN, their data.
- `o_stall`, out, 1, combinational; freeze PC, IF/ID and ID/EX.
- `o_alu_zero`, out, 1, registered ALU zero flag.
- `o_write_reg`, out, NB_ADDRESS_REGISTROS, registered destination register.
- `o_ctrl_wb`, out, NB_CTRL_WB, registered WB control.
- `o_ctrl_mem`, out, NB_CTRL_MEM, registered MEM control.
- `o_add_execute`, out, LEN, registered branch target.
- `o_alu_result`, out, LEN, registered result.
- `o_dato2`, out, LEN, registered store data.

## Operation
- **Forwarding, A from rs and B from rt.** Use MEM data if `i_fwd_mem_we` is set and `i_fwd_mem_reg` equals the source register, which must be non-zero. Otherwise use WB data under the same rule. Otherwise use `i_dato1`/`i_dato2`. MEM has priority over WB. Register 0 is never forwarded.
- **ALU datapath.**
  - The ALU second operand is `i_sign_extend` when ALUSrc is set, else forwarded B.
  - `o_dato2` carries forwarded B.
  - `o_write_reg` is `i_rd` when RegDst is set, else `i_rt`.
  - `o_add_execute` is `i_adder_id + (i_sign_extend << 2)`, truncated to LEN.
- **Result select.**
  - MFHI → HI; MFLO → LO.
  - MTHI/MTLO write A into HI/LO at the edge that retires the instruction.
  - All other ops → ALU result.
- **MDU FSM states.**
  - IDLE: a start is `i_valid` with op 1 or 2. On a start, latch the operands, clear the accumulator, set cnt = LEN−1 and go to BUSY.
  - BUSY: perform one shift-add (MULTU) or restoring-divide (DIVU) step per cycle. When cnt = 0, write HI/LO and go to DONE; otherwise decrement cnt.
  - DONE: the instruction retires into EX/MEM, then the FSM returns to IDLE. A start is never accepted in DONE.
- **MULTU.** {HI,LO} = A × B, full 2·LEN-bit product.
- **DIVU.** LO = A / B, HI = A % B.
  - Divide by zero: LO = all ones, HI = A.
- **Stall behaviour.**
  - `o_stall` = (IDLE && start) || BUSY.
  - While stalled, EX/MEM loads a bubble: ctrl_wb, ctrl_mem, write_reg and alu_zero are 0; data fields hold.
- **Reset.** Every output, HI, LO, cnt and the accumulators go to 0; the FSM goes to IDLE. A reset in the middle of an operation abandons it, and `o_stall` drops immediately.
- **Invalid instructions.** With `i_valid` = 0, EX/MEM loads a bubble and the MDU ignores `i_mdu_op`.

## Timing
- Non-MDU instructions: 1-cycle latency, ID/EX inputs to registered outputs.
- MULTU/DIVU:
  - `o_stall` is high for exactly LEN+1 consecutive cycles: the issue cycle plus LEN BUSY cycles.
  - The DONE cycle has `o_stall` low and the instruction enters EX/MEM at its closing edge.
- HI/LO are valid from the DONE cycle onward. An MFHI/MFLO immediately following the operation reads the new value with no extra stall.
- Back-to-back MULTU: the second one issues in the cycle after DONE.

## Configuration
- `EX_DIV_EN` defined: DIVU is implemented as described.
- `EX_DIV_EN` undefined:
  - The divider datapath is not synthesised.
  - DIVU is treated as op 0: no stall, HI/LO unchanged, result is the ALU result.

## Test plan
- LEN=32, MULTU A=0xFFFF_FFFF, B=2 → `o_stall` high 33 cycles; then HI=0x0000_0001, LO=0xFFFF_FFFE; a following MFLO gives `o_alu_result`=0xFFFF_FFFE.
- DIVU 100/7 → LO=14, HI=2. DIVU 5/0 → LO=0xFFFF_FFFF, HI=5. With `EX_DIV_EN` undefined, DIVU 100/7 → no stall, HI/LO unchanged.
- Forwarding priority: `i_rs`=8, MEM reg 8 with data 0x10, WB reg 8 with data 0x20, `i_dato1`=0x30, ADD with B=1 → `o_alu_result`=0x11. With `i_rs`=0 and MEM/WB reg 0 → 0x31.
- Reset mid-operation: `i_rst` asserted in BUSY cycle 10 of a MULTU → `o_stall`=0 immediately; all outputs, HI and LO are 0; the next MULTU 3×4 gives LO=12.
- Bubble and branch target: `i_valid`=0 → `o_ctrl_wb`=`o_ctrl_mem`=0. With `i_valid`=1, `i_adder_id`=0x100 and immediate 0xFFFF_FFFF → `o_add_execute`=0xFC.
- MTHI A=0xABCD then MFHI → `o_alu_result`=0xABCD, no stall.
